// File: rtl/div_seq_pkg.sv
// Shared state encoding and watchdog constants for the division sequencer.
// The watchdog is built only when DIV_SEQ_TIMEOUT_EN is defined.
package div_seq_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      WRITE  = 3'd3,
      EXC    = 3'd4
   } state_e;

   localparam int TIMEOUT_CYCLES = 64;
   localparam int WD_W           = $clog2(TIMEOUT_CYCLES) + 1;
endpackage

// File: rtl/div_watchdog.sv
// Counts consecutive cycles while enabled; expired flags the last permitted cycle.
// Only instantiated by div_sequencer when DIV_SEQ_TIMEOUT_EN is defined.
module div_watchdog
   import div_seq_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [WD_W-1:0] count_q;
   logic [WD_W-1:0] count_d;

   // count_q holds the number of enabled cycles already completed, so it
   // reads TIMEOUT_CYCLES-1 during the final permitted cycle
   assign expired = (count_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/div_sequencer.sv
// Sequences a signed division through an external multi-cycle divider and owns HI/LO.
// Optional WAIT watchdog enabled by defining DIV_SEQ_TIMEOUT_EN.
module div_sequencer
   import div_seq_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        op_start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        mthi_we,
   input  logic        mtlo_we,
   input  logic [31:0] mt_data,
   output logic        div_start,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic        div_finished,
   input  logic        div_zero,
   input  logic [31:0] div_quotient,
   input  logic [31:0] div_remainder,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall,
   output logic        div_zero_exc,
   output logic        div_timeout
);
   state_e      state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] dividend_q, dividend_d;
   logic [31:0] divisor_q, divisor_d;
   logic        div_start_q, div_start_d;
   logic        div_zero_exc_q, div_zero_exc_d;
   logic        timeout_hit;

`ifdef DIV_SEQ_TIMEOUT_EN
   logic wd_expired;

   div_watchdog u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (state_q != WAIT),
      .enable  (state_q == WAIT),
      .expired (wd_expired)
   );

   // A divider completion or zero report in the final cycle still wins
   assign timeout_hit = (state_q == WAIT) && wd_expired && !div_zero && !div_finished;
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      case (state_q)
         IDLE: begin
            if (mthi_we) hi_d = mt_data;
            if (mtlo_we) lo_d = mt_data;
            if (op_start) begin
               if (op_b != 32'd0) begin
                  dividend_d = op_a;
                  divisor_d  = op_b;
                  state_d    = LAUNCH;
               end else begin
                  state_d = EXC;
               end
            end
         end
         LAUNCH: state_d = WAIT;
         WAIT: begin
            if (div_zero) begin
               state_d = EXC;
            end else if (div_finished) begin
               state_d = WRITE;
            end else if (timeout_hit) begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            lo_d    = div_quotient;
            hi_d    = div_remainder;
            state_d = IDLE;
         end
         EXC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Pulse outputs are registered so they align exactly with their state
      div_start_d    = (state_d == LAUNCH);
      div_zero_exc_d = (state_d == EXC);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         hi_q           <= '0;
         lo_q           <= '0;
         dividend_q     <= '0;
         divisor_q      <= '0;
         div_start_q    <= 1'b0;
         div_zero_exc_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         hi_q           <= hi_d;
         lo_q           <= lo_d;
         dividend_q     <= dividend_d;
         divisor_q      <= divisor_d;
         div_start_q    <= div_start_d;
         div_zero_exc_q <= div_zero_exc_d;
      end
   end

   assign hi           = hi_q;
   assign lo           = lo_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   assign div_start    = div_start_q;
   assign div_zero_exc = div_zero_exc_q;
   assign div_timeout  = timeout_hit;
   assign stall        = (state_q != IDLE);
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a small behavioural divider (2-cycle latency).
// Define DIV_SEQ_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_div_sequencer;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        op_start = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        mthi_we = 1'b0;
   logic        mtlo_we = 1'b0;
   logic [31:0] mt_data = '0;
   logic        div_start;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_finished;
   logic        div_zero;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall;
   logic        div_zero_exc;
   logic        div_timeout;

   int passed = 0;
   int total  = 0;

   // divider stub: mode 0 normal, 1 never finishes, 2 reports zero on completion
   int          mode = 0;
   int          cnt_q = 0;
   logic        fin_q = 1'b0;
   logic        zr_q = 1'b0;
   logic        force_fin = 1'b0;
   logic [31:0] dq_q = '0;
   logic [31:0] dr_q = '0;

   assign div_finished  = fin_q | force_fin;
   assign div_zero      = zr_q;
   assign div_quotient  = dq_q;
   assign div_remainder = dr_q;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      fin_q <= 1'b0;
      zr_q  <= 1'b0;
      if (div_start) begin
         if (div_divisor != 32'd0) begin
            dq_q <= $signed(div_dividend) / $signed(div_divisor);
            dr_q <= $signed(div_dividend) % $signed(div_divisor);
         end
         cnt_q <= (mode == 1) ? 0 : 2;
      end else if (cnt_q > 0) begin
         cnt_q <= cnt_q - 1;
         if (cnt_q == 1) begin
            fin_q <= 1'b1;
            zr_q  <= (mode == 2);
         end
      end
   end

   div_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .op_start     (op_start),
      .op_a         (op_a),
      .op_b         (op_b),
      .mthi_we      (mthi_we),
      .mtlo_we      (mtlo_we),
      .mt_data      (mt_data),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_finished (div_finished),
      .div_zero     (div_zero),
      .div_quotient (div_quotient),
      .div_remainder(div_remainder),
      .hi           (hi),
      .lo           (lo),
      .stall        (stall),
      .div_zero_exc (div_zero_exc),
      .div_timeout  (div_timeout)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // issue one op, then run until stall drops (bounded at 200 cycles)
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output int starts, output int excs);
      op_a = a; op_b = b; op_start = 1'b1;
      tick();
      op_start = 1'b0;
      cyc = 0; starts = 0; excs = 0;
      while (stall && cyc < 200) begin
         if (div_start) starts++;
         if (div_zero_exc) excs++;
         cyc++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi); else passed++;
      total++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
      total++; if ({div_start, div_zero_exc, div_timeout} !== 3'b000)
         $display("FAIL reset_pulses: got %b want 000", {div_start, div_zero_exc, div_timeout}); else passed++;
      total++; if ({div_dividend, div_divisor} !== 64'd0)
         $display("FAIL reset_operands: got %h want 0", {div_dividend, div_divisor}); else passed++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int cyc, starts;
      op_a = 32'd7; op_b = 32'd2; op_start = 1'b1;
      #1;
      total++; if (stall !== 1'b0) $display("FAIL basic_idle_stall: got %b want 0", stall); else passed++;
      tick();
      op_start = 1'b0;
      total++; if ({stall, div_start} !== 2'b11) $display("FAIL basic_launch: stall/start got %b want 11", {stall, div_start}); else passed++;
      total++; if (div_dividend !== 32'd7 || div_divisor !== 32'd2)
         $display("FAIL basic_operands: got %h/%h want 7/2", div_dividend, div_divisor); else passed++;
      cyc = 0; starts = 0;
      while (stall && cyc < 200) begin
         if (div_start) starts++;
         cyc++;
         tick();
      end
      total++; if (cyc !== 5) $display("FAIL basic_stall_cycles: got %0d want 5", cyc); else passed++;
      total++; if (starts !== 1) $display("FAIL basic_start_pulses: got %0d want 1", starts); else passed++;
      total++; if (lo !== 32'd3) $display("FAIL basic_lo: got %h want 3", lo); else passed++;
      total++; if (hi !== 32'd1) $display("FAIL basic_hi: got %h want 1", hi); else passed++;
   endtask

   task automatic test_signed();
      int cyc, starts, excs;
      run_op(32'd15, 32'hFFFF_FFFC, cyc, starts, excs);
      total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL signed1_lo: got %h want fffffffd", lo); else passed++;
      total++; if (hi !== 32'd3) $display("FAIL signed1_hi: got %h want 3", hi); else passed++;
      run_op(32'hFFFF_FFF6, 32'd3, cyc, starts, excs);
      total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL signed2_lo: got %h want fffffffd", lo); else passed++;
      total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL signed2_hi: got %h want ffffffff", hi); else passed++;
   endtask

   task automatic test_zero_divisor();
      mt_data = 32'd5; mthi_we = 1'b1;
      tick();
      mthi_we = 1'b0; mtlo_we = 1'b1;
      tick();
      mtlo_we = 1'b0;
      total++; if (hi !== 32'd5 || lo !== 32'd5) $display("FAIL mt_preset: got %h/%h want 5/5", hi, lo); else passed++;
      op_a = 32'd1; op_b = 32'd0; op_start = 1'b1;
      tick();
      op_start = 1'b0;
      // an mt write during EXC must be dropped
      mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'd9;
      total++; if ({stall, div_start, div_zero_exc} !== 3'b101)
         $display("FAIL zero_exc_state: stall/start/exc got %b want 101", {stall, div_start, div_zero_exc}); else passed++;
      tick();
      mthi_we = 1'b0; mtlo_we = 1'b0;
      total++; if ({stall, div_zero_exc} !== 2'b00) $display("FAIL zero_exc_end: stall/exc got %b want 00", {stall, div_zero_exc}); else passed++;
      total++; if (hi !== 32'd5 || lo !== 32'd5) $display("FAIL zero_hilo: got %h/%h want 5/5", hi, lo); else passed++;
   endtask

   task automatic test_mt_same_cycle();
      int cyc, starts;
      op_a = 32'd9; op_b = 32'd4; op_start = 1'b1;
      mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'h77;
      tick();
      op_start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
      total++; if (hi !== 32'h77 || lo !== 32'h77) $display("FAIL mt_same_cycle: got %h/%h want 77/77", hi, lo); else passed++;
      cyc = 0; starts = 0;
      while (stall && cyc < 200) begin
         cyc++;
         tick();
      end
      total++; if (lo !== 32'd2 || hi !== 32'd1) $display("FAIL mt_overwrite: got lo %h hi %h want 2/1", lo, hi); else passed++;
   endtask

   task automatic test_ignore_restart();
      int cyc, starts;
      op_a = 32'd20; op_b = 32'd6; op_start = 1'b1;
      tick();
      op_start = 1'b0;
      tick();
      // now in WAIT: a second request must not be accepted or queued
      op_a = 32'd100; op_b = 32'd1; op_start = 1'b1;
      tick();
      op_start = 1'b0;
      total++; if (div_dividend !== 32'd20 || div_divisor !== 32'd6)
         $display("FAIL restart_operands: got %h/%h want 14/6", div_dividend, div_divisor); else passed++;
      cyc = 0; starts = 0;
      while (stall && cyc < 200) begin
         if (div_start) starts++;
         cyc++;
         tick();
      end
      total++; if (lo !== 32'd3 || hi !== 32'd2) $display("FAIL restart_result: got lo %h hi %h want 3/2", lo, hi); else passed++;
      tick();
      tick();
      total++; if (stall !== 1'b0 || starts !== 0) $display("FAIL restart_queued: stall %b starts %0d want 0/0", stall, starts); else passed++;
   endtask

   task automatic test_zero_in_wait();
      int cyc, starts, excs;
      mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'h11;
      tick();
      mthi_we = 1'b0; mt_data = 32'h22;
      tick();
      mtlo_we = 1'b0;
      mode = 2;
      run_op(32'd8, 32'd2, cyc, starts, excs);
      mode = 0;
      total++; if (excs !== 1) $display("FAIL waitzero_exc_pulses: got %0d want 1", excs); else passed++;
      total++; if (hi !== 32'h11 || lo !== 32'h22) $display("FAIL waitzero_hilo: got %h/%h want 11/22", hi, lo); else passed++;
   endtask

   task automatic test_reset_mid();
      mode = 1;
      op_a = 32'd50; op_b = 32'd7; op_start = 1'b1;
      tick();
      op_start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      total++; if (stall !== 1'b0) $display("FAIL resetmid_async: stall got %b want 0", stall); else passed++;
      tick();
      reset = 1'b0;
      force_fin = 1'b1;
      tick();
      force_fin = 1'b0;
      tick();
      mode = 0;
      total++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL resetmid_hilo: got %h/%h want 0/0", hi, lo); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL resetmid_idle: stall got %b want 0", stall); else passed++;
   endtask

   task automatic test_timeout();
      int n;
      int seen;
      mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'h3C;
      tick();
      mthi_we = 1'b0; mtlo_we = 1'b0;
      mode = 1;
      op_a = 32'd5; op_b = 32'd1; op_start = 1'b1;
      tick();
      op_start = 1'b0;
      tick();
`ifdef DIV_SEQ_TIMEOUT_EN
      n = 1;
      while (!div_timeout && n < 100) begin
         tick();
         n++;
      end
      total++; if (n !== 64 || stall !== 1'b1) $display("FAIL timeout_cycle: got wait cycle %0d stall %b want 64/1", n, stall); else passed++;
      tick();
      total++; if ({stall, div_timeout} !== 2'b00) $display("FAIL timeout_release: stall/timeout got %b want 00", {stall, div_timeout}); else passed++;
      total++; if (hi !== 32'h3C || lo !== 32'h3C) $display("FAIL timeout_hilo: got %h/%h want 3c/3c", hi, lo); else passed++;
`else
      seen = 0;
      for (n = 0; n < 80; n++) begin
         if (div_timeout) seen++;
         tick();
      end
      total++; if (seen !== 0 || stall !== 1'b1) $display("FAIL no_timeout: pulses %0d stall %b want 0/1", seen, stall); else passed++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
`endif
      mode = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_zero_divisor();
      test_mt_same_cycle();
      test_ignore_restart();
      test_zero_in_wait();
      test_reset_mid();
      test_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
